// File: rtl/mem_arbiter.sv
// mem_arbiter: owns the byte-wide single-port RAM bus and shares it between
// the IFetch line-refill port and the LSB load/store port. Round-robin
// arbitration, byte-serial bus sequencing, registered outputs.
// Optional feature: define IO_STALL_EN to hold IO-region stores while the
// UART TX buffer reports full.
module mem_arbiter #(
  parameter int         IF_BLK_BYTES = 64,
  parameter logic [1:0] IO_BASE_HI   = 2'b11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rob_set_pc_en,
  input  logic                      if_en,
  input  logic [31:0]               if_pc,
  output logic                      if_done,
  output logic [IF_BLK_BYTES*8-1:0] if_data,
  input  logic                      lsb_en,
  input  logic                      lsb_wr,
  input  logic [31:0]               lsb_addr,
  input  logic [2:0]                lsb_size,
  input  logic [31:0]               lsb_wdata,
  output logic                      lsb_done,
  output logic [31:0]               lsb_rdata,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full
);

  localparam int             CW       = $clog2(IF_BLK_BYTES + 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]  BLK_SIZE = CW'(IF_BLK_BYTES);
  localparam logic [CW-2:0]  IDX_ONE  = (CW-1)'(1);
  localparam logic           GRANT_IF = 1'b0;
  localparam logic           GRANT_LS = 1'b1;

  typedef enum logic [1:0] {IDLE, RD_IF, RD_LS, WR_LS} state_t;

  state_t                    state, state_n;
  logic [CW-1:0]             cnt, cnt_n, size, size_n;
  logic [31:0]               base, base_n, wdata, wdata_n;
  logic                      last_grant, last_grant_n;
  logic [31:0]               rd_buf, rd_buf_n;
  logic [IF_BLK_BYTES*8-1:0] line_buf, line_buf_n, if_data_n;
  logic [31:0]               mem_a_n, lsb_rdata_n;
  logic [7:0]                mem_dout_n;
  logic                      mem_wr_n, if_done_n, lsb_done_n;

  logic                      if_ok, ls_ok, grant_ls, grant_if;
  logic                      stall_cur, stall_new;
  logic [CW-1:0]             cnt_inc, size_m1, ls_size;
  logic [CW-2:0]             byte_idx;
  logic [31:0]               cnt_ext;

`ifdef IO_STALL_EN
  assign stall_cur = (base[17:16] == IO_BASE_HI) && io_buffer_full;
  assign stall_new = (lsb_addr[17:16] == IO_BASE_HI) && io_buffer_full;
`else
  logic unused_io;
  assign stall_cur = 1'b0;
  assign stall_new = 1'b0;
  assign unused_io = ^{io_buffer_full, IO_BASE_HI};
`endif

  // A requester still showing its done pulse has not dropped en yet; skip it.
  assign if_ok    = if_en && !if_done && !rob_set_pc_en;
  assign ls_ok    = lsb_en && !lsb_done;
  assign grant_ls = ls_ok && (!if_ok || (last_grant == GRANT_IF));
  assign grant_if = if_ok && !grant_ls;

  assign cnt_inc  = cnt + CNT_ONE;
  assign size_m1  = size - CNT_ONE;
  assign byte_idx = cnt[CW-2:0] - IDX_ONE;
  assign cnt_ext  = 32'(cnt);

  // Decode LSB byte count; anything other than 1 or 2 is a word access.
  always_comb begin
    case (lsb_size)
      3'd1:    ls_size = CW'(1);
      3'd2:    ls_size = CW'(2);
      default: ls_size = CW'(4);
    endcase
  end

  // Next-state and next-output logic for the bus sequencer.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    size_n       = size;
    base_n       = base;
    wdata_n      = wdata;
    last_grant_n = last_grant;
    rd_buf_n     = rd_buf;
    line_buf_n   = line_buf;
    mem_a_n      = mem_a;
    mem_dout_n   = mem_dout;
    mem_wr_n     = mem_wr;
    if_data_n    = if_data;
    lsb_rdata_n  = lsb_rdata;
    if_done_n    = 1'b0;
    lsb_done_n   = 1'b0;
    case (state)
      IDLE: begin
        mem_wr_n = 1'b0;
        if (grant_ls) begin
          base_n       = lsb_addr;
          size_n       = ls_size;
          wdata_n      = lsb_wdata;
          cnt_n        = {CW{1'b0}};
          last_grant_n = GRANT_LS;
          mem_a_n      = lsb_addr;
          rd_buf_n     = 32'd0;
          if (lsb_wr) begin
            state_n    = WR_LS;
            mem_dout_n = lsb_wdata[7:0];
            mem_wr_n   = !stall_new;
          end else begin
            state_n    = RD_LS;
          end
        end else if (grant_if) begin
          base_n       = if_pc;
          size_n       = BLK_SIZE;
          cnt_n        = {CW{1'b0}};
          last_grant_n = GRANT_IF;
          mem_a_n      = if_pc;
          state_n      = RD_IF;
        end else begin
          state_n      = IDLE;
        end
      end
      RD_IF: begin
        if (rob_set_pc_en) begin
          state_n = IDLE;
        end else begin
          if (cnt != {CW{1'b0}}) begin
            line_buf_n[{byte_idx, 3'b000} +: 8] = mem_din;
          end else begin
            line_buf_n = line_buf;
          end
          if (cnt == size) begin
            if_data_n = line_buf_n;
            if_done_n = 1'b1;
            state_n   = IDLE;
          end else begin
            cnt_n   = cnt_inc;
            mem_a_n = base + cnt_ext + 32'd1;
          end
        end
      end
      RD_LS: begin
        if (cnt != {CW{1'b0}}) begin
          rd_buf_n[{byte_idx[1:0], 3'b000} +: 8] = mem_din;
        end else begin
          rd_buf_n = rd_buf;
        end
        if (cnt == size) begin
          lsb_rdata_n = rd_buf_n;
          lsb_done_n  = 1'b1;
          state_n     = IDLE;
        end else begin
          cnt_n   = cnt_inc;
          mem_a_n = base + cnt_ext + 32'd1;
        end
      end
      WR_LS: begin
        if (mem_wr) begin
          if (cnt == size_m1) begin
            mem_wr_n   = 1'b0;
            lsb_done_n = 1'b1;
            state_n    = IDLE;
          end else begin
            cnt_n      = cnt_inc;
            mem_a_n    = base + cnt_ext + 32'd1;
            mem_dout_n = wdata[{cnt_inc[1:0], 3'b000} +: 8];
            mem_wr_n   = !stall_cur;
          end
        end else begin
          mem_wr_n = !stall_cur;
        end
      end
      default: begin
        state_n  = IDLE;
        mem_wr_n = 1'b0;
      end
    endcase
  end

  // State and output registers; rdy low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= {CW{1'b0}};
      size       <= {CW{1'b0}};
      base       <= 32'd0;
      wdata      <= 32'd0;
      last_grant <= GRANT_IF;
      rd_buf     <= 32'd0;
      line_buf   <= {(IF_BLK_BYTES*8){1'b0}};
      mem_a      <= 32'd0;
      mem_dout   <= 8'd0;
      mem_wr     <= 1'b0;
      if_data    <= {(IF_BLK_BYTES*8){1'b0}};
      lsb_rdata  <= 32'd0;
      if_done    <= 1'b0;
      lsb_done   <= 1'b0;
    end else if (rdy) begin
      state      <= state_n;
      cnt        <= cnt_n;
      size       <= size_n;
      base       <= base_n;
      wdata      <= wdata_n;
      last_grant <= last_grant_n;
      rd_buf     <= rd_buf_n;
      line_buf   <= line_buf_n;
      mem_a      <= mem_a_n;
      mem_dout   <= mem_dout_n;
      mem_wr     <= mem_wr_n;
      if_data    <= if_data_n;
      lsb_rdata  <= lsb_rdata_n;
      if_done    <= if_done_n;
      lsb_done   <= lsb_done_n;
    end
  end

endmodule
